// File: rtl/sensor_spi_responder_pkg.sv
// Shared constants, state encoding and sample-generator helper for the
// serial sensor responder.
package sensor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t TAIL  = 2'd2;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Minimum sclk high/low phase and cs setup, in clk_100M cycles.
    localparam int MIN_PHASE = 4;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sensor_spi_responder_if.sv
// Serial link between the acquisition master and the sensor responder.
interface sensor_spi_responder_if;
    logic cs;
    logic sclk;
    logic sen_rst;
    logic sdo;

    modport master (output cs, output sclk, output sen_rst, input sdo);
    modport slave  (input cs, input sclk, input sen_rst, output sdo);
endinterface

// File: rtl/sensor_spi_responder_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin, with rise/fall pulses
// derived from the synchronized value and its one-cycle-delayed copy.
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_100M,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta;
    logic sync_q;
    logic dly;

    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            meta   <= RST_VAL;
            sync_q <= RST_VAL;
            dly    <= RST_VAL;
        end else begin
            meta   <= din;
            sync_q <= meta;
            dly    <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~dly;
    assign fall  = ~sync_q & dly;
endmodule

// File: rtl/sensor_spi_responder.sv
// Serial sensor model: shifts a DATA_W-bit sample out MSB first while the
// master toggles sclk under cs, then advances the sample for the next frame.
//
// state | meaning
// IDLE  | cs high, sdo held low, waiting for cs fall
// SHIFT | frame in progress, bits driven on sclk fall, counted on sclk rise
// TAIL  | all DATA_W bits counted, extra rises flag overrun, cs rise completes
module sensor_spi_responder
    import sensor_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int PATTERN_MODE = 0,
    parameter logic [DATA_W-1:0] SEED = DATA_W'(DEFAULT_SEED)
) (
    input  logic                   clk_100M,
    input  logic                   reset,
    sensor_spi_responder_if.slave  spi,
    output logic                   frame_done,
    output logic                   frame_abort,
    output logic                   overrun,
    output logic                   busy,
    output logic [15:0]            frame_cnt
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic sen_lvl, sen_rise, sen_fall;

    state_t            state;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] sample_next;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;

    // cs idles high, so its synchronizer resets high to avoid a false fall.
    sync_edge_det #(.RST_VAL(1'b1)) u_cs_sync (
        .clk_100M(clk_100M), .reset(reset), .din(spi.cs),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge_det #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk_100M(clk_100M), .reset(reset), .din(spi.sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_det #(.RST_VAL(1'b0)) u_sen_sync (
        .clk_100M(clk_100M), .reset(reset), .din(spi.sen_rst),
        .level(sen_lvl), .rise(sen_rise), .fall(sen_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{cs_lvl, sclk_lvl, sen_rise, sen_fall};

    generate
        if (PATTERN_MODE == 1) begin : g_lfsr
            assign sample_next = lfsr16_next(sample[15:0]);
        end else begin : g_count
            assign sample_next = sample + DATA_W'(1);
        end
    endgenerate

    always_ff @(posedge clk_100M or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sample      <= SEED;
            shreg       <= '0;
            bit_cnt     <= '0;
            spi.sdo     <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            if (sen_lvl) begin
                state     <= IDLE;
                sample    <= SEED;
                shreg     <= '0;
                bit_cnt   <= '0;
                spi.sdo   <= 1'b0;
                busy      <= 1'b0;
                frame_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        spi.sdo <= 1'b0;
                        if (cs_fall) begin
                            shreg   <= sample;
                            spi.sdo <= sample[DATA_W-1];
                            bit_cnt <= '0;
                            overrun <= 1'b0;
                            busy    <= 1'b1;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        // cs rise is checked first so a coincident sclk edge is dropped.
                        if (cs_rise) begin
                            frame_abort <= 1'b1;
                            spi.sdo     <= 1'b0;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end else if (sclk_rise) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                                spi.sdo <= 1'b0;
                                state   <= TAIL;
                            end
                        end else if (sclk_fall && (bit_cnt < CNT_W'(DATA_W))) begin
                            shreg   <= {shreg[DATA_W-2:0], 1'b0};
                            spi.sdo <= shreg[DATA_W-2];
                        end
                    end
                    TAIL: begin
                        spi.sdo <= 1'b0;
                        if (cs_rise) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                            sample     <= sample_next;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else if (sclk_rise) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
